// File: rtl/dac_stream.sv
// dac_stream: buffered stereo PCM serialiser for an I2S / left-justified DAC.
// Generates mclk, bclk, lrck and sdti from the system clock, fed by a pair FIFO.
module dac_stream #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int MCLK_DIV     = 4,
    parameter int BCLK_DIV     = 16,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_WIDTH-1:0]   wr_l,
    input  logic [SAMPLE_WIDTH-1:0]   wr_r,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      fmt,
    input  logic                      mute,
    input  logic                      clr_underrun,
    output logic                      underrun,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      frame,
    output logic                      mclk,
    output logic                      bclk,
    output logic                      lrck,
    output logic                      sdti
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int SL = SLOT_WIDTH;
    localparam int FW = 2 * SLOT_WIDTH;
    localparam int PW = $clog2(BCLK_DIV);
    localparam int KW = $clog2(FW);
    localparam int MW = $clog2(MCLK_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [PW-1:0] P_LAST = PW'(BCLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(BCLK_DIV / 2);
    localparam logic [KW-1:0] K_LAST = KW'(FW - 1);
    localparam logic [KW-1:0] K_HALF = KW'(SL);
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV / 2 - 1);
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    // Place a sample in its slot: LJ starts at bit 0, I2S one bit later.
    function automatic logic [SL-1:0] slot(input logic lj,
                                           input logic [SW-1:0] s);
        logic [SL-1:0] ext;
        ext = {{(SL - SW){1'b0}}, s};
        return lj ? (ext << (SL - SW)) : (ext << (SL - SW - 1));
    endfunction

    logic [MW-1:0] mclk_cnt;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;
    logic [KW-1:0] k;
    logic [KW-1:0] k_n;
    logic [FW-1:0] sh;
    logic [FW-1:0] load_word;
    logic [SW-1:0] mem_l [DEPTH];
    logic [SW-1:0] mem_r [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level_n;
    logic          bit_end;
    logic          fetch;
    logic          fetch_n;
    logic          empty;
    logic          push;
    logic          pop;

    always_comb begin
        bit_end = (phase == P_LAST);
        phase_n = bit_end ? '0 : phase + 1'b1;
        k_n = k;
        if (bit_end)
            k_n = (k == K_LAST) ? '0 : k + 1'b1;
        fetch   = bit_end && (k == K_LAST);
        fetch_n = (phase_n == P_LAST) && (k_n == K_LAST);
        empty   = (level == '0);
        push    = wr_valid && wr_ready;
        pop     = fetch && !empty;
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (pop && !push)
            level_n = level - 1'b1;
        load_word = '0;
        if (!empty && !mute)
            load_word = {slot(fmt, mem_l[rd_ptr]), slot(fmt, mem_r[rd_ptr])};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= wr_l;
            mem_r[wr_ptr] <= wr_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
            phase    <= '0;
            k        <= '0;
            bclk     <= 1'b0;
            lrck     <= 1'b0;
            sdti     <= 1'b0;
            sh       <= '0;
            frame    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            if (mclk_cnt == M_LAST) begin
                mclk_cnt <= '0;
                mclk     <= ~mclk;
            end else begin
                mclk_cnt <= mclk_cnt + 1'b1;
            end
            phase <= phase_n;
            k     <= k_n;
            bclk  <= (phase_n >= P_HALF);
            frame <= fetch_n;
            // Serial outputs advance only on the bclk falling edge.
            if (bit_end) begin
                lrck <= (k_n >= K_HALF);
                if (fetch) begin
                    sdti <= load_word[FW-1];
                    sh   <= load_word << 1;
                end else begin
                    sdti <= sh[FW-1];
                    sh   <= sh << 1;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level    <= level_n;
            wr_ready <= (level_n != L_FULL);
            if (fetch && empty)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_stream.sv
// Directed bench for dac_stream: frame timing, both formats, FIFO, mute,
// underrun and mid-frame reset, with hand-built expected serial words.
module tb_dac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] wr_l;
    logic [23:0] wr_r;
    logic        wr_valid;
    logic        wr_ready;
    logic        fmt;
    logic        mute;
    logic        clr_underrun;
    logic        underrun;
    logic [2:0]  level;
    logic        frame;
    logic        mclk;
    logic        bclk;
    logic        lrck;
    logic        sdti;

    int tests = 0;
    int fails = 0;

    dac_stream dut (
        .clk(clk), .rst(rst), .wr_l(wr_l), .wr_r(wr_r),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .fmt(fmt), .mute(mute),
        .clr_underrun(clr_underrun), .underrun(underrun), .level(level),
        .frame(frame), .mclk(mclk), .bclk(bclk), .lrck(lrck), .sdti(sdti)
    );

    always #10 clk = ~clk;

    function automatic logic [63:0] i2s(input logic [23:0] l,
                                        input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    function automatic logic [63:0] lj(input logic [23:0] l,
                                       input logic [23:0] r);
        return {l, 8'b0, r, 8'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 1200);
        chk("frame_seen", 64'(frame), 64'd1);
    endtask

    task automatic put(input logic [23:0] l, input logic [23:0] r);
        wr_l = l;
        wr_r = r;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Samples sdti mid bit (bclk high) for all 64 slot bits.
    task automatic capture(input int skip, input logic [63:0] exp,
                           input string tag);
        logic [63:0] w;
        int bad;
        w = '0;
        bad = 0;
        repeat (skip) @(negedge clk);
        for (int b = 0; b < 64; b++) begin
            if (b > 0)
                repeat (16) @(negedge clk);
            w[63-b] = sdti;
            if (bclk !== 1'b1 || lrck !== (b >= 32))
                bad++;
        end
        chk(tag, w, exp);
        chk({tag, "_clk"}, 64'(bad), 64'd0);
    endtask

    logic [23:0] al = 24'h0FF0F6;
    logic [23:0] ar = 24'hAA55A6;
    logic [23:0] bl = 24'h800001;
    logic [23:0] br = 24'h7FFFFF;
    logic [23:0] dl [5];
    logic [23:0] dr [5];

    initial begin
        int n;
        dl = '{24'h111111, 24'h222222, 24'h345678, 24'h444444, 24'h555555};
        dr = '{24'h999999, 24'hAAAAAA, 24'hC0FFEE, 24'hBBBBBB, 24'hCCCCCC};
        rst = 1'b1;
        wr_l = '0;
        wr_r = '0;
        wr_valid = 1'b0;
        fmt = 1'b0;
        mute = 1'b0;
        clr_underrun = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mclk", 64'(mclk), 64'd0);
        chk("rst_bclk", 64'(bclk), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_sdti", 64'(sdti), 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("mclk_wave", 64'(mclk), 64'((i >> 1) & 1));
            chk("bclk_wave", 64'(bclk), 64'((i % 16) >= 8));
        end

        // First fetch finds an empty FIFO; a write in the same cycle stays.
        wait_frame();
        chk("pre_underrun", 64'(underrun), 64'd0);
        put(al, ar);
        chk("fetch_underrun", 64'(underrun), 64'd1);
        chk("fetch_wr_level", 64'(level), 64'd1);
        chk("frame_pulse_len", 64'(frame), 64'd0);
        capture(8, 64'd0, "zero_frame");

        wait_frame();
        @(negedge clk);
        chk("pop_level", 64'(level), 64'd0);
        chk("sticky_underrun", 64'(underrun), 64'd1);
        capture(8, i2s(al, ar), "i2s_a");

        wait_frame();
        capture(9, 64'd0, "underrun_zero");
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("clr_underrun", 64'(underrun), 64'd0);

        wait_frame();
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("set_beats_clr", 64'(underrun), 64'd1);

        // Left-justified, then fmt flips back mid-frame.
        fmt = 1'b1;
        put(al, ar);
        wait_frame();
        @(negedge clk);
        fmt = 1'b0;
        put(bl, br);
        capture(7, lj(al, ar), "lj_a");
        wait_frame();
        capture(9, i2s(bl, br), "i2s_b");

        // FIFO fill with the 5th write held off until a fetch.
        wait_frame();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_l = dl[i];
            wr_r = dr[i];
            wr_valid = 1'b1;
            @(negedge clk);
            chk("fill_level", 64'(level), 64'(i + 1));
            chk("fill_ready", 64'(wr_ready), 64'(i < 3));
        end
        wr_l = dl[4];
        wr_r = dr[4];
        wait_frame();
        chk("full_hold", 64'(level), 64'd4);
        @(negedge clk);
        chk("after_pop_level", 64'(level), 64'd3);
        chk("after_pop_ready", 64'(wr_ready), 64'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("fifth_level", 64'(level), 64'd4);
        chk("fifth_ready", 64'(wr_ready), 64'd0);

        // Mute consumes one pair; the following pair plays normally.
        mute = 1'b1;
        wait_frame();
        @(negedge clk);
        mute = 1'b0;
        chk("mute_level", 64'(level), 64'd3);
        capture(8, 64'd0, "mute_zero");
        wait_frame();
        capture(9, i2s(dl[2], dr[2]), "unmute");

        // Reset at k=20, phase 0.
        wait_frame();
        repeat (321) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mclk", 64'(mclk), 64'd0);
        chk("mid_rst_bclk", 64'(bclk), 64'd0);
        chk("mid_rst_sdti", 64'(sdti), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_ready", 64'(wr_ready), 64'd1);
        chk("mid_rst_underrun", 64'(underrun), 64'd0);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lrck !== 1'b1 && n < 2000);
        chk("lrck_rise", 64'(n), 64'd512);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dac_stream.md
Name: dac_stream

Overview:
- Parametrised successor to the single-sample DAC controller.
- Serialises buffered stereo PCM frames to an external audio DAC over an I2S or left-justified serial link, and generates mclk, bclk, lrck and sdti from the 50 MHz system clock.
- Samples arrive over a valid/ready handshake into an internal FIFO, so the producer is decoupled from frame timing.
- Reports underruns and FIFO level to the control/status logic.

Parameters:
SAMPLE_WIDTH, 24, bits per channel sample; must be < SLOT_WIDTH
SLOT_WIDTH, 32, bclk periods per channel slot (frame = 2*SLOT_WIDTH)
MCLK_DIV, 4, clk cycles per mclk period; even, >=2
BCLK_DIV, 16, clk cycles per bclk period; even, >=2
DEPTH, 4, FIFO entries (stereo pairs); power of 2, >=2

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
wr_l  in  SAMPLE_WIDTH  left sample, two's complement
wr_r  in  SAMPLE_WIDTH  right sample
wr_valid  in  1  pair offered
wr_ready  out  1  FIFO not full
fmt  in  1  0 = I2S, 1 = left-justified
mute  in  1  transmit zeros
clr_underrun  in  1  clears underrun flag
underrun  out  1  sticky underrun flag
level  out  clog2(DEPTH)+1  FIFO occupancy
frame  out  1  one-cycle pulse at each fetch point
mclk  out  1  DAC master clock
bclk  out  1  bit clock
lrck  out  1  word select, 0 = left
sdti  out  1  serial data, MSB first

Behaviour:
- Clock and reset: single clock domain. Synchronous, active-high reset. All outputs are registered.
- Reset values: mclk=0, bclk=0, lrck=0, sdti=0, frame=0, underrun=0, level=0, wr_ready=1. FIFO is emptied, shift registers are zeroed, all counters restart at frame bit 0, phase 0.
- Reset mid-frame: the frame is aborted immediately and the outputs take their reset values on the next edge.
- mclk: free-running. Toggles every MCLK_DIV/2 cycles and is independent of the frame counters.
- Frame counters:
  - Phase counter 0..BCLK_DIV-1; bit index k = 0..2*SLOT_WIDTH-1, which wraps.
  - bclk = 0 for phase < BCLK_DIV/2, 1 otherwise.
  - lrck = 1 for k >= SLOT_WIDTH.
  - lrck and sdti change only at phase 0 (bclk falling edge).
  - Default frame = 1024 clk cycles (48.828 kHz).
- Data mapping, slot bit j = k mod SLOT_WIDTH, channel sample s:
  - I2S: j=0 -> 0; 1<=j<=SAMPLE_WIDTH -> s[SAMPLE_WIDTH-j]; otherwise 0.
  - Left-justified: j<SAMPLE_WIDTH -> s[SAMPLE_WIDTH-1-j]; otherwise 0.
- Fetch point: the cycle with k = 2*SLOT_WIDTH-1 and phase = BCLK_DIV-1.
  - frame pulses high for this one cycle.
  - fmt and mute are latched here; mid-frame changes take effect next frame.
  - FIFO non-empty: pop the head into the L/R shift registers for the next frame (zeros loaded instead if mute is latched, and the pair is still consumed).
  - FIFO empty: load zeros and set underrun.
- First frame after reset always transmits zeros.
- FIFO:
  - Write occurs when wr_valid && wr_ready.
  - wr_ready = (level != DEPTH).
  - Write and pop in the same cycle: pop decides emptiness on the pre-write level. A write into an empty FIFO at the fetch point still counts as underrun; the written pair stays queued and level ends at 1.
  - Full FIFO at fetch with wr_valid: the pop frees a slot, but wr_ready is still 0 that cycle, so no write.
- underrun:
  - Set at a failing fetch, cleared by clr_underrun.
  - Set and clear in the same cycle: set wins.
- Latency: a pair written before fetch point F has its first bit (left MSB) leave at k=1 (I2S) or k=0 (left-justified) of the frame starting after F.

Test Plan:
- I2S default: after reset, write L=0x0FF0F6, R=0xAA55A6, fmt=0 -> lrck period 1024 cycles, bclk period 16. Frame 2 carries slot bits j=1..24 = 0x0FF0F6 left and 0xAA55A6 right, remaining bits 0. underrun=1 from the first fetch.
- Left-justified: same pair, fmt=1 -> the MSB (0 for L, 1 for R) appears at j=0, 24 bits, then 8 zeros. Toggling fmt mid-frame has no effect until the next frame.
- FIFO fill, DEPTH=4: 5 back-to-back writes with no fetch -> level 1,2,3,4; wr_ready drops after the 4th write. The 5th write is accepted only after the next frame pulse.
- Underrun: stop writing with 1 pair queued -> that pair is sent, then a zero frame, underrun=1. clr_underrun clears it; clr_underrun asserted during a failing fetch leaves underrun=1.
- Mute: queue 2 pairs, assert mute before the fetch -> zero frame, level decremented. Releasing mute resumes with the second pair.
- Reset mid-frame at k=20: outputs return to 0 next cycle, level=0, and the next lrck rise occurs 32*16 cycles after reset release.
